fifo_uart_tx: RTL

- Downstream consumer of the 16x8 byte FIFO: pops one byte at a time and serializes it as an asynchronous UART frame on a single line.
- Frame format: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Sits between the FIFO read port and the chip TX pin; paces FIFO reads so the FIFO drains exactly at line rate.

---
 rtl/fifo_uart_tx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-fed UART transmitter: pops one byte per frame and serializes it LSB first
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  input  logic [7:0] fifo_rd_data,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic          stop_idx, stop_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_bit, parity_next;
  logic          tx_next, done_next;
  logic          cnt_last;

  assign cnt_last = (cnt == CNT_LAST);
  assign busy     = (state != IDLE);
  // Gated by reset so the FIFO is never popped while the transmitter is held in reset.
  assign fifo_rd  = reset & (state == IDLE) & tx_en & ~fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      bit_idx    <= bit_idx_next;
      stop_idx   <= stop_idx_next;
      shift_reg  <= shift_next;
      parity_bit <= parity_next;
      tx         <= tx_next;
      frame_done <= done_next;
    end
  end

  // tx is registered, so each transition loads the line value of the state being entered.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt_last ? '0 : cnt + 1'b1;
    bit_idx_next  = bit_idx;
    stop_idx_next = stop_idx;
    shift_next    = shift_reg;
    parity_next   = parity_bit;
    tx_next       = tx;
    done_next     = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        tx_next  = 1'b1;
        if (fifo_rd) begin
          state_next  = START;
          shift_next  = fifo_rd_data;
          parity_next = (^fifo_rd_data) ^ ODD;
          tx_next     = 1'b0;
        end
      end
      START: begin
        if (cnt_last) begin
          state_next   = DATA;
          bit_idx_next = '0;
          tx_next      = shift_reg[0];
        end
      end
      DATA: begin
        if (cnt_last) begin
          if (bit_idx == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_next = PARITY;
              tx_next    = parity_bit;
            end else begin
              state_next    = STOP;
              stop_idx_next = 1'b0;
              tx_next       = 1'b1;
            end
          end else begin
            shift_next   = shift_reg >> 1;
            tx_next      = shift_reg[1];
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (cnt_last) begin
          state_next    = STOP;
          stop_idx_next = 1'b0;
          tx_next       = 1'b1;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (cnt_last) begin
          if (stop_idx == STOP_LAST) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            stop_idx_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule
